// File: rtl/sm_debouncer_filt.sv
// Multi-channel input conditioner: synchronizer chain, per-channel stability
// counter against a live threshold, and registered edge pulses.
module sm_debouncer_filt #(
    parameter int   WIDTH       = 1,
    parameter int   SYNC_STAGES = 2,
    parameter int   CNT_W       = 16,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    input  logic [CNT_W-1:0] stableCycles,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);

    logic [WIDTH-1:0] syncReg [SYNC_STAGES];
    logic [WIDTH-1:0] syncOut;
    logic [CNT_W-1:0] cnt     [WIDTH];
    logic [CNT_W-1:0] cntNext [WIDTH];
    logic [CNT_W-1:0] limit;
    logic [WIDTH-1:0] qNext;
    logic [WIDTH-1:0] riseNext;
    logic [WIDTH-1:0] fallNext;
    logic             changedNext;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                syncReg[k] <= {WIDTH{RESET_VAL}};
            end
        end else begin
            syncReg[0] <= d;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                syncReg[k] <= syncReg[k-1];
            end
        end
    end

    assign syncOut = syncReg[SYNC_STAGES-1];

    // A threshold of zero is treated as one, so the commit limit never underflows.
    always_comb begin
        limit = '0;
        if (stableCycles != '0) begin
            limit = stableCycles - CNT_W'(1);
        end
    end

    always_comb begin
        qNext    = q;
        riseNext = '0;
        fallNext = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cntNext[i] = '0;
            if (syncOut[i] != q[i]) begin
                if (cnt[i] >= limit) begin
                    qNext[i]    = syncOut[i];
                    riseNext[i] = syncOut[i];
                    fallNext[i] = ~syncOut[i];
                end else begin
                    cntNext[i] = cnt[i] + CNT_W'(1);
                end
            end
        end
        changedNext = (|riseNext) | (|fallNext);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q       <= {WIDTH{RESET_VAL}};
            rise    <= '0;
            fall    <= '0;
            changed <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            q       <= qNext;
            rise    <= riseNext;
            fall    <= fallNext;
            changed <= changedNext;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= cntNext[i];
            end
        end
    end

endmodule

// File: tb/tb_sm_debouncer_filt.sv
// Bench for sm_debouncer_filt: directed scenarios with literal expectations plus
// randomized traffic, all checked against a run-length model of the debouncer.
module tb_sm_debouncer_filt;

    localparam int   WIDTH       = 4;
    localparam int   SYNC_STAGES = 2;
    localparam int   CNT_W       = 16;
    localparam logic RESET_VAL   = 1'b0;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] d;
    logic [CNT_W-1:0] stableCycles;
    logic [WIDTH-1:0] q, rise, fall;
    logic             changed;

    int assertCount = 0;
    int failCount   = 0;

    logic [WIDTH-1:0] hist [SYNC_STAGES];
    logic [WIDTH-1:0] mq, mRise, mFall;
    logic             mChanged;
    int               run [WIDTH];
    bit               modelValid = 1'b0;
    logic [WIDTH-1:0] fallSeen = '0;

    sm_debouncer_filt #(
        .WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES), .CNT_W(CNT_W), .RESET_VAL(RESET_VAL)
    ) dut (
        .clk(clk), .rst(rst), .d(d), .stableCycles(stableCycles),
        .q(q), .rise(rise), .fall(fall), .changed(changed)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [WIDTH-1:0] dVal, input logic [CNT_W-1:0] nVal, input logic rVal);
        d            = dVal;
        stableCycles = nVal;
        rst          = rVal;
    endtask

    task automatic waitEdges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Model: a channel commits once the synchronized level has disagreed with q
    // for max(N,1) consecutive edges; any agreement restarts the run.
    always @(posedge clk) begin
        int n;
        logic [WIDTH-1:0] s;
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) hist[k] = {WIDTH{RESET_VAL}};
            for (int i = 0; i < WIDTH; i++) run[i] = 0;
            mq = {WIDTH{RESET_VAL}};
            mRise = '0; mFall = '0; mChanged = 1'b0;
            modelValid = 1'b1;
        end else if (modelValid) begin
            n = (stableCycles == 0) ? 1 : int'(stableCycles);
            s = hist[SYNC_STAGES-1];
            mRise = '0; mFall = '0;
            for (int i = 0; i < WIDTH; i++) begin
                if (s[i] == mq[i]) begin
                    run[i] = 0;
                end else begin
                    run[i] = run[i] + 1;
                    if (run[i] >= n) begin
                        mq[i] = s[i];
                        if (s[i]) mRise[i] = 1'b1; else mFall[i] = 1'b1;
                        run[i] = 0;
                    end
                end
            end
            mChanged = (mRise != 0) || (mFall != 0);
            for (int k = SYNC_STAGES-1; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = d;
        end
    end

    always @(negedge clk) begin
        if (modelValid) begin
            checkOutput("modelQ", 32'(q), 32'(mq));
            checkOutput("modelRise", 32'(rise), 32'(mRise));
            checkOutput("modelFall", 32'(fall), 32'(mFall));
            checkOutput("modelChanged", 32'(changed), 32'(mChanged));
            fallSeen = fallSeen | fall;
        end
    end

    initial begin
        #1_500_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [WIDTH-1:0] dv;
        logic             ch3;

        // Reset and latency
        applyStimulus(4'hF, 16'd5, 1'b1);
        waitEdges(3);
        checkOutput("resetQ", 32'(q), 32'h0);
        checkOutput("resetRise", 32'(rise), 32'h0);
        checkOutput("resetChanged", 32'(changed), 32'h0);
        rst = 1'b0;
        waitEdges(6);
        checkOutput("latQ6", 32'(q), 32'h0);
        waitEdges(1);
        checkOutput("latQ7", 32'(q), 32'hF);
        checkOutput("latRise7", 32'(rise), 32'hF);
        checkOutput("latChanged7", 32'(changed), 32'h1);
        checkOutput("latFall7", 32'(fall), 32'h0);
        waitEdges(1);
        checkOutput("latRise8", 32'(rise), 32'h0);
        checkOutput("latChanged8", 32'(changed), 32'h0);

        // Glitch rejection: 3-cycle low pulse is swallowed
        fallSeen = '0;
        applyStimulus(4'hE, 16'd5, 1'b0);
        waitEdges(3);
        d = 4'hF;
        waitEdges(10);
        checkOutput("glitchQ", 32'(q), 32'hF);
        checkOutput("glitchNoFall", 32'(fallSeen), 32'h0);

        // 5-cycle low pulse commits, then the high level commits back
        d = 4'hE;
        waitEdges(5);
        d = 4'hF;
        waitEdges(2);
        checkOutput("pulse5Q", 32'(q), 32'hE);
        checkOutput("pulse5Fall", 32'(fall), 32'h1);
        waitEdges(4);
        checkOutput("pulse5QHold", 32'(q), 32'hE);
        waitEdges(1);
        checkOutput("pulse5Back", 32'(q), 32'hF);
        checkOutput("pulse5Rise", 32'(rise), 32'h1);

        // Thresholds 0 and 1 both commit on the third edge
        applyStimulus(4'hE, 16'd0, 1'b0);
        waitEdges(2);
        checkOutput("n0Before", 32'(q), 32'hF);
        waitEdges(1);
        checkOutput("n0Commit", 32'(q), 32'hE);
        applyStimulus(4'hF, 16'd1, 1'b0);
        waitEdges(2);
        checkOutput("n1Before", 32'(q), 32'hE);
        waitEdges(1);
        checkOutput("n1Commit", 32'(q), 32'hF);

        // Live threshold reduction after six counted mismatches
        applyStimulus(4'hE, 16'd10, 1'b0);
        waitEdges(8);
        checkOutput("liveBefore", 32'(q), 32'hF);
        stableCycles = 16'd4;
        waitEdges(1);
        checkOutput("liveCommit", 32'(q), 32'hE);
        d = 4'hF;
        waitEdges(5);
        checkOutput("liveRestart5", 32'(q), 32'hE);
        waitEdges(1);
        checkOutput("liveRestart6", 32'(q), 32'hF);

        // Independent channels: ch1 rises, ch2 falls, ch3 chatters
        applyStimulus(4'hD, 16'd3, 1'b0);
        waitEdges(8);
        checkOutput("indepSetup", 32'(q), 32'hD);
        ch3 = 1'b0;
        for (int k = 0; k < 10; k++) begin
            d = {ch3, 1'b0, 1'b1, 1'b1};
            ch3 = ~ch3;
            waitEdges(1);
            checkOutput("indepQ3", 32'(q[3]), 32'h1);
            if (k == 4) begin
                checkOutput("indepRise", 32'(rise), 32'h2);
                checkOutput("indepFall", 32'(fall), 32'h4);
                checkOutput("indepChanged", 32'(changed), 32'h1);
            end
        end
        checkOutput("indepFinalQ", 32'(q), 32'hB);

        // Reset mid-count discards the pending change
        applyStimulus(4'hB, 16'd5, 1'b0);
        waitEdges(6);
        d = 4'hF;
        waitEdges(5);
        rst = 1'b1;
        waitEdges(1);
        checkOutput("midRstQ", 32'(q), 32'h0);
        checkOutput("midRstRise", 32'(rise), 32'h0);
        checkOutput("midRstChanged", 32'(changed), 32'h0);
        rst = 1'b0;
        waitEdges(6);
        checkOutput("midRstHold", 32'(q), 32'h0);
        waitEdges(1);
        checkOutput("midRstCommit", 32'(q), 32'hF);
        checkOutput("midRstRise2", 32'(rise), 32'hF);

        // Maximum threshold: 65535 mismatch cycles, no wrap
        applyStimulus(4'hE, 16'hFFFF, 1'b0);
        waitEdges(65536);
        checkOutput("maxBefore", 32'(q), 32'hF);
        waitEdges(1);
        checkOutput("maxCommit", 32'(q), 32'hE);
        checkOutput("maxFall", 32'(fall), 32'h1);
        applyStimulus(4'hF, 16'd2, 1'b0);
        waitEdges(5);

        // Randomized traffic checked by the model
        dv = d;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < WIDTH; i++) begin
                if ($urandom_range(0, 5) == 0) dv[i] = ~dv[i];
            end
            d = dv;
            if ($urandom_range(0, 49) == 0) stableCycles = CNT_W'($urandom_range(0, 6));
            rst = ($urandom_range(0, 299) == 0);
            waitEdges(1);
        end
        rst = 1'b0;
        waitEdges(2);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/sm_debouncer_filt.md
Name: sm_debouncer_filt

Overview:
- Multi-channel input conditioner for switches, buttons and other asynchronous board inputs.
- Successor to the plain 2-flop metastability filter.
- Adds a parametrised synchronizer depth, a per-channel stability counter with a run-time threshold, and edge-detect pulse outputs.
- Sits between board pins and the clock divider / register-address selection logic in the hardware top level.

Parameters:
- WIDTH, 1: number of independent input channels.
- SYNC_STAGES, 2: synchronizer flops per channel; legal values are 2 and above.
- CNT_W, 16: width of each stability counter and of the threshold input.
- RESET_VAL, 0: 1-bit value replicated into every bit of q at reset.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous reset, active-high.
- d  input  WIDTH  raw asynchronous inputs.
- stableCycles  input  CNT_W  threshold N, the number of consecutive cycles a new level must persist; used live, not latched.
- q  output  WIDTH  debounced level, registered.
- rise  output  WIDTH  one-cycle pulse on each channel's 0->1 commit of q, registered.
- fall  output  WIDTH  one-cycle pulse on each channel's 1->0 commit of q, registered.
- changed  output  1  registered OR of all rise and fall bits for the same cycle.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high. All state updates only on the rising edge of clk; no latches, no combinational paths from input to output.
- Reset (rst high at an edge):
  - all synchronizer flops become RESET_VAL;
  - q becomes RESET_VAL in every bit;
  - all counters become 0;
  - rise, fall and changed become 0.
  - rst overrides all other activity. Reset mid-count discards the count; no pulse is produced for the discarded change.
- Synchronizer: s[i] is d[i] delayed through SYNC_STAGES flops. No logic between the flops.
- Effective threshold: Neff = max(stableCycles, 1). A value of 0 behaves as 1.
- Per-channel update at each edge, when rst is low:
  - If s[i] == q[i]: cnt[i] <= 0 and no pulse.
  - Else if cnt[i] >= Neff-1: q[i] <= s[i], cnt[i] <= 0, and rise[i] or fall[i] <= 1 according to direction.
  - Else: cnt[i] <= cnt[i]+1.
- Pulses: rise and fall are 0 on every other edge, so each pulse is high exactly one cycle. rise[i] and fall[i] are never high together.
- Latency: if d changes before edge E1 and then holds, q changes and the pulse asserts at edge E(SYNC_STAGES+Neff).
  - Example: SYNC_STAGES=2 and N=5 gives edge 7.
- Glitch rejection: if s returns to q before the count completes, cnt clears. No output change, no pulse.
- Counter bound: cnt never exceeds Neff-1 and never wraps. Maximum threshold is 2^CNT_W-1.
- Threshold change mid-count:
  - if the new Neff-1 is at or below the current cnt, the commit occurs at the next edge where the mismatch persists;
  - if it is larger, counting continues toward the new value.
- Channels are fully independent. Simultaneous commits on several channels are allowed, and changed is 1 for that single cycle.
- Output timing: q, rise, fall and changed all update on the same edge.

Test Plan:
- Reset and latency (WIDTH=4, SYNC_STAGES=2, RESET_VAL=0):
  - stimulus: hold rst 3 cycles with d=4'hF, then release with N=5;
  - required: q=0, rise=0 and changed=0 throughout reset; q=4'hF on the 7th edge after release; rise=4'hF and changed=1 for exactly that one cycle; fall=0.
- Glitch rejection (N=5):
  - stimulus: q[0]=1, then d[0] pulses low for 3 cycles;
  - required: q[0] stays 1 and no fall pulse. Repeating the test with a 5-cycle low pulse: q[0]=0 for one window and fall[0] high one cycle, then a rise pulse once the high level persists 5 cycles.
- Threshold edge cases:
  - stimulus: stableCycles=0 and stableCycles=1;
  - required: both commit a change on the 3rd edge after d changes.
  - stimulus: stableCycles=16'hFFFF;
  - required: the commit occurs after exactly 65535 mismatch cycles, with no wrap.
- Live threshold reduction:
  - stimulus: N=10, mismatch held until cnt=6, then set N=4;
  - required: commit on the next edge; cnt returns to 0.
- Independent channels:
  - stimulus: ch1 rises and ch2 falls on the same cycle (N=3); ch3 toggles every cycle;
  - required: rise[1] and fall[2] in the same single cycle with changed=1; q[3] never changes.
- Reset mid-count:
  - stimulus: assert rst while cnt=3 of N=5;
  - required: no pulse; q=RESET_VAL after the reset edge, and counting restarts from 0 after release.
